rhd_miso_capture: RTL and testbench
===================================

# rhd_miso_capture

Front-end receive stage of the RHD headstage interface. Consumes the SPI frame timing (CS, SCLK) produced by the RHD SPI master and the returning MISO lines, applies a programmable per-line round-trip delay compensation in `aclk` cycles, and deserializes one 16-bit word per MISO line per CS frame. Completed frames are presented as one wide word on a valid/ready stream to the downstream packetizer. The master's delay register (byte offset 0x4, 4 bits per line) drives `delay_cfg` directly.

## Interface
- `NUM_MISO`, 8: number of MISO lines captured in parallel.
- `WORD_BITS`, 16: bits per line per CS frame.
- `aclk`  in  1  sole clock; SCLK/CS are generated in this domain.
- `aresetn`  in  1  asynchronous, active-low reset.
- `enable`  in  1  capture enable (acquisition run bit).
- `cs`  in  1  chip select from SPI master, active low.
- `sclk`  in  1  SPI clock from SPI master (aclk/4).
- `miso`  in  NUM_MISO  MISO lines, already synchronized into `aclk`.
- `delay_cfg`  in  4*NUM_MISO  per-line delay, line i at bits [4i+3:4i], 0..15 aclk cycles.
- `clear`  in  1  pulse; clears `overflow` and `frame_err_cnt`.
- `m_tvalid`  out  1  frame word valid.
- `m_tready`  in  1  downstream accept.
- `m_tdata`  out  WORD_BITS*NUM_MISO  line i word at [16i+15:16i], MSB first on the wire.
- `overflow`  out  1  sticky: a completed frame was dropped.
- `frame_err_cnt`  out  16  count of aborted/incomplete frames, saturating.

## Operation
- Edge detect: `sclk_q` register; rise strobe `rs = sclk & ~sclk_q & ~cs & enable`.
- Strobe delay line: 16-deep shift register `sd[0]=rs`, `sd[k]=sd[k-1]` delayed one cycle per stage.
- Per line i: when `sd[delay_cfg_i]` is 1 and `bitcnt_i < WORD_BITS`, shift `miso[i]` into `shreg_i` LSB (left shift, MSB first) and increment `bitcnt_i` (5 bits). Strobes arriving after CS rises are still taken (captures delayed tail bits).
- Frame states: IDLE, CAPTURE, DONE.
  - IDLE -> CAPTURE on CS falling edge with `enable`=1; all `bitcnt_i` cleared that cycle.
  - CAPTURE -> DONE when every `bitcnt_i == WORD_BITS`; that cycle load `m_tdata` from all `shreg_i` and set `m_tvalid`.
  - CAPTURE -> CAPTURE on a new CS falling edge before completion: increment `frame_err_cnt` (saturate at 0xFFFF), clear counters, start new frame.
  - DONE -> CAPTURE on next CS falling edge; DONE -> IDLE on `enable`=0.
  - Any state -> IDLE when `enable`=0; in-progress frame discarded, no error count.
- Output buffer: single register. On load while `m_tvalid`=1 and `m_tready`=0: keep old word, drop new, set `overflow`. Load with `m_tvalid & m_tready` same cycle: old word accepted, new word loaded, `m_tvalid` stays 1. `m_tvalid` clears on handshake with no load.
- `m_tdata` stable while `m_tvalid & ~m_tready`.
- `clear` same cycle as an error/overflow event: event wins (flag/count ends at 1/1).
- Master constraint: CS high time >= 16 aclk cycles so delayed tail bits land before the next frame.

## Timing
- Reset: `m_tvalid`=0, `m_tdata`=0, `overflow`=0, `frame_err_cnt`=0, state IDLE, all `bitcnt_i`=0, `sd`=0, `sclk_q`=0.
- Delay 0: bit sampled in the first cycle `sclk` is observed high; delay d: d cycles later.
- Frame latency: `m_tvalid` high 1 cycle after the cycle capturing the last line's 16th bit, i.e. last SCLK rise + max(delay) + 1.
- Throughput: one frame per CS cycle; no backpressure to SPI master.
- `delay_cfg` is sampled per bit; change only while `enable`=0.

## Test plan
- Reset/idle: hold `aresetn`=0 200 ns, release with `enable`=0, toggle SCLK/CS -> `m_tvalid` never rises, all outputs 0.
- Delay 1 all lines (`delay_cfg`=0x11111111), model drives MISO one aclk after each SCLK rise with line i = 0xA5A0+i -> one beat, `m_tdata` line i = 0xA5A0+i.
- Mixed delays 0..7 on lines 0..7, per-line model matching delay, word 0x1234 -> all lines 0x1234; same stimulus with line 3 delay set 0 but model at 3 -> line 3 mismatch detected by bench.
- Backpressure: `m_tready`=0 across two frames -> first word held unchanged, `overflow`=1; pulse `clear` -> `overflow`=0.
- Short frame: CS rises after 10 SCLK pulses, next frame normal -> `frame_err_cnt`=1, only the second frame output.
- Abort: drop `enable` after 8 bits, re-enable for a full frame -> `frame_err_cnt`=0, one valid beat with the second frame's data.

Source files
------------

// File: rtl/rhd_miso_capture_if.sv
// Frame-word stream between the MISO capture stage and the downstream packetizer.
// tdata carries one WORD_BITS word per MISO line, line i at [WORD_BITS*i +: WORD_BITS].
interface rhd_miso_capture_if #(
    parameter int NUM_MISO  = 8,
    parameter int WORD_BITS = 16
);
    logic                          tvalid;
    logic                          tready;
    logic [WORD_BITS*NUM_MISO-1:0] tdata;

    modport master (
        output tvalid,
        output tdata,
        input  tready
    );

    modport slave (
        input  tvalid,
        input  tdata,
        output tready
    );
endinterface

// File: rtl/rhd_miso_capture.sv
// RHD headstage receive stage: per-line round-trip delay compensation and MISO
// deserialization, one wide word per CS frame presented on a valid/ready stream.
module rhd_miso_capture #(
    parameter int NUM_MISO  = 8,
    parameter int WORD_BITS = 16
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  enable_i,
    input  logic                  cs_i,
    input  logic                  sclk_i,
    input  logic [NUM_MISO-1:0]   miso_i,
    input  logic [4*NUM_MISO-1:0] delay_cfg_i,
    input  logic                  clear_i,
    rhd_miso_capture_if.master    m_axis,
    output logic                  overflow_o,
    output logic [15:0]           frame_err_cnt_o
);

    localparam int         DW       = WORD_BITS * NUM_MISO;
    localparam logic [4:0] FULL_CNT = 5'(WORD_BITS);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DONE    = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic                 sclk_q;
    logic                 cs_q;
    logic [15:1]          sd_q;
    logic [15:0]          sd_s;
    logic                 rise_s;
    logic                 cs_fall_s;
    logic [NUM_MISO-1:0]  tap_s;
    logic [4:0]           bitcnt_q   [NUM_MISO];
    logic [4:0]           bitcnt_d   [NUM_MISO];
    logic [4:0]           cnt_next_s [NUM_MISO];
    logic [WORD_BITS-1:0] shreg_q    [NUM_MISO];
    logic [WORD_BITS-1:0] shreg_d    [NUM_MISO];
    logic                 all_full_s;
    logic [DW-1:0]        pack_s;
    logic                 start_s;
    logic                 err_s;
    logic                 load_s;
    logic                 tvalid_q, tvalid_d;
    logic [DW-1:0]        tdata_q, tdata_d;
    logic                 overflow_q, overflow_d;
    logic [15:0]          err_cnt_q, err_cnt_d;
    logic [15:0]          err_base_s;

    // SCLK rise strobe, CS falling edge, and tap 0 of the strobe delay line
    always_comb begin
        rise_s    = sclk_i & ~sclk_q & ~cs_i & enable_i;
        cs_fall_s = cs_q & ~cs_i;
        sd_s      = {sd_q, rise_s};
    end

    // Per-line sampling: each line picks its own delayed strobe tap
    always_comb begin
        all_full_s = 1'b1;
        pack_s     = '0;
        tap_s      = '0;
        for (int i = 0; i < NUM_MISO; i++) begin
            tap_s[i]      = sd_s[delay_cfg_i[4*i +: 4]];
            cnt_next_s[i] = bitcnt_q[i];
            shreg_d[i]    = shreg_q[i];
            if ((state_q == ST_CAPTURE) && tap_s[i] && (bitcnt_q[i] < FULL_CNT)) begin
                shreg_d[i]    = {shreg_q[i][WORD_BITS-2:0], miso_i[i]};
                cnt_next_s[i] = bitcnt_q[i] + 5'd1;
            end else begin
                cnt_next_s[i] = bitcnt_q[i];
            end
            if (cnt_next_s[i] != FULL_CNT) begin
                all_full_s = 1'b0;
            end else begin
                all_full_s = all_full_s;
            end
            pack_s[WORD_BITS*i +: WORD_BITS] = shreg_d[i];
        end
    end

    // Frame sequencing; a disable always wins and discards the frame silently
    always_comb begin
        state_d = state_q;
        start_s = 1'b0;
        err_s   = 1'b0;
        load_s  = 1'b0;
        if (!enable_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cs_fall_s) begin
                        state_d = ST_CAPTURE;
                        start_s = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_CAPTURE: begin
                    if (all_full_s) begin
                        state_d = ST_DONE;
                        load_s  = 1'b1;
                    end else if (cs_fall_s) begin
                        state_d = ST_CAPTURE;
                        start_s = 1'b1;
                        err_s   = 1'b1;
                    end else begin
                        state_d = ST_CAPTURE;
                    end
                end
                ST_DONE: begin
                    if (cs_fall_s) begin
                        state_d = ST_CAPTURE;
                        start_s = 1'b1;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Bit counters restart on every frame start, otherwise follow sampling
    always_comb begin
        for (int i = 0; i < NUM_MISO; i++) begin
            if (start_s) begin
                bitcnt_d[i] = 5'd0;
            end else begin
                bitcnt_d[i] = cnt_next_s[i];
            end
        end
    end

    // Output buffer, overflow flag and error counter; events override clear
    always_comb begin
        tvalid_d   = tvalid_q;
        tdata_d    = tdata_q;
        overflow_d = clear_i ? 1'b0 : overflow_q;
        err_base_s = clear_i ? 16'h0000 : err_cnt_q;
        err_cnt_d  = err_base_s;
        if (load_s) begin
            if (tvalid_q && !m_axis.tready) begin
                overflow_d = 1'b1;
            end else begin
                tvalid_d = 1'b1;
                tdata_d  = pack_s;
            end
        end else if (tvalid_q && m_axis.tready) begin
            tvalid_d = 1'b0;
        end else begin
            tvalid_d = tvalid_q;
        end
        if (err_s && (err_base_s != 16'hFFFF)) begin
            err_cnt_d = err_base_s + 16'd1;
        end else begin
            err_cnt_d = err_base_s;
        end
    end

    // State, edge-detect, delay line, per-line and output registers
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q    <= ST_IDLE;
            sclk_q     <= 1'b0;
            cs_q       <= 1'b1;
            sd_q       <= '0;
            tvalid_q   <= 1'b0;
            tdata_q    <= '0;
            overflow_q <= 1'b0;
            err_cnt_q  <= 16'h0000;
            for (int i = 0; i < NUM_MISO; i++) begin
                bitcnt_q[i] <= 5'd0;
                shreg_q[i]  <= '0;
            end
        end else begin
            state_q    <= state_d;
            sclk_q     <= sclk_i;
            cs_q       <= cs_i;
            sd_q       <= sd_s[14:0];
            tvalid_q   <= tvalid_d;
            tdata_q    <= tdata_d;
            overflow_q <= overflow_d;
            err_cnt_q  <= err_cnt_d;
            for (int i = 0; i < NUM_MISO; i++) begin
                bitcnt_q[i] <= bitcnt_d[i];
                shreg_q[i]  <= shreg_d[i];
            end
        end
    end

    assign m_axis.tvalid   = tvalid_q;
    assign m_axis.tdata    = tdata_q;
    assign overflow_o      = overflow_q;
    assign frame_err_cnt_o = err_cnt_q;

endmodule

// File: tb/tb_rhd_miso_capture.sv
// Bench for rhd_miso_capture: a cycle-level SPI/MISO model drives frames, expected
// words go into a queue, and a negedge monitor pops and compares each accepted beat.
module tb_rhd_miso_capture;

    localparam int N  = 8;
    localparam int W  = 16;
    localparam int DW = N * W;

    logic          aclk = 1'b0;
    logic          aresetn;
    logic          enable_i;
    logic          cs_i;
    logic          sclk_i;
    logic          clear_i;
    logic [N-1:0]  miso_i;
    logic [4*N-1:0] delay_cfg_i;
    logic          overflow_o;
    logic [15:0]   frame_err_cnt_o;

    rhd_miso_capture_if #(.NUM_MISO(N), .WORD_BITS(W)) axis_if ();

    rhd_miso_capture #(.NUM_MISO(N), .WORD_BITS(W)) dut (
        .aclk            (aclk),
        .aresetn         (aresetn),
        .enable_i        (enable_i),
        .cs_i            (cs_i),
        .sclk_i          (sclk_i),
        .miso_i          (miso_i),
        .delay_cfg_i     (delay_cfg_i),
        .clear_i         (clear_i),
        .m_axis          (axis_if),
        .overflow_o      (overflow_o),
        .frame_err_cnt_o (frame_err_cnt_o)
    );

    always #5 aclk = ~aclk;

    int            total = 0;
    int            bad   = 0;
    int            beats = 0;
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] prev_data;
    logic          prev_stall = 1'b0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    // Monitor: stability under backpressure, then scoreboard compare on each handshake
    always @(negedge aclk) begin
        logic [DW-1:0] e;
        if (prev_stall) begin
            check("hold_valid", DW'(axis_if.tvalid), DW'(1'b1));
            check("hold_data", axis_if.tdata, prev_data);
        end
        if (axis_if.tvalid && axis_if.tready) begin
            beats++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_beat: got %h want no beat", axis_if.tdata);
            end else begin
                e = exp_q.pop_front();
                check("beat_data", axis_if.tdata, e);
            end
        end
        prev_stall = axis_if.tvalid && !axis_if.tready;
        prev_data  = axis_if.tdata;
    end

    task automatic tick();
        @(posedge aclk);
        #2;
    endtask

    // One CS frame: SCLK = aclk/4, rises at t = 2+4k; line i presents bit k only at
    // t = 2+4k+dm_i and drives 0 in every other cycle; CS stays high 20 cycles after.
    task automatic run_frame(input logic [DW-1:0] word, input logic [31:0] dm,
                             input int nbits, input int en_off);
        int            cs_low;
        int            u;
        logic [W-1:0]  lw;
        cs_low = 2 + 4 * nbits;
        for (int t = 0; t < cs_low + 20; t++) begin
            tick();
            enable_i = (t < en_off);
            cs_i     = (t < cs_low) ? 1'b0 : 1'b1;
            sclk_i   = (t >= 2) && (t < cs_low) && (((t - 2) % 4) < 2);
            for (int i = 0; i < N; i++) begin
                u  = t - int'(dm[4*i +: 4]) - 2;
                lw = word[W*i +: W];
                miso_i[i] = (u >= 0 && (u % 4) == 0 && (u / 4) < nbits) ? lw[15 - u/4] : 1'b0;
            end
        end
    endtask

    task automatic set_delay(input logic [31:0] cfg);
        tick();
        enable_i = 1'b0;
        repeat (4) tick();
        delay_cfg_i = cfg;
        tick();
    endtask

    task automatic pulse_clear();
        tick();
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge aclk);
            n++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s: got %0d beats outstanding want 0", name, exp_q.size());
        end
    endtask

    function automatic logic [DW-1:0] make_word(input logic [15:0] base, input bit add_idx);
        logic [DW-1:0] w;
        w = '0;
        for (int i = 0; i < N; i++) begin
            w[W*i +: W] = add_idx ? (base + 16'(i)) : base;
        end
        return w;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want test completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [DW-1:0] w;
        logic [DW-1:0] w2;
        aresetn      = 1'b0;
        enable_i     = 1'b0;
        cs_i         = 1'b1;
        sclk_i       = 1'b0;
        clear_i      = 1'b0;
        miso_i       = '0;
        delay_cfg_i  = 32'h1111_1111;
        axis_if.tready = 1'b1;

        // Reset and disabled operation
        repeat (20) @(posedge aclk);
        @(negedge aclk);
        check("rst_tvalid", DW'(axis_if.tvalid), DW'(1'b0));
        check("rst_tdata", axis_if.tdata, DW'(1'b0));
        check("rst_overflow", DW'(overflow_o), DW'(1'b0));
        check("rst_errcnt", DW'(frame_err_cnt_o), DW'(16'h0000));
        tick();
        aresetn = 1'b1;
        run_frame(make_word(16'hA5A0, 1'b1), 32'h1111_1111, 16, 0);
        @(negedge aclk);
        check("dis_tvalid", DW'(axis_if.tvalid), DW'(1'b0));
        check("dis_tdata", axis_if.tdata, DW'(1'b0));
        check("dis_overflow", DW'(overflow_o), DW'(1'b0));
        check("dis_errcnt", DW'(frame_err_cnt_o), DW'(16'h0000));

        // Delay 1 on every line
        w = make_word(16'hA5A0, 1'b1);
        exp_q.push_back(w);
        run_frame(w, 32'h1111_1111, 16, 1000);
        drain("delay1");

        // Mixed delays 0..7
        set_delay(32'h7654_3210);
        w = make_word(16'h1234, 1'b0);
        exp_q.push_back(w);
        run_frame(w, 32'h7654_3210, 16, 1000);
        drain("mixed");

        // Line 3 configured for 0 while the wire is 3 late: it samples idle zeros
        set_delay(32'h7654_0210);
        w2 = w;
        w2[W*3 +: W] = 16'h0000;
        exp_q.push_back(w2);
        run_frame(w, 32'h7654_3210, 16, 1000);
        drain("misdelay");

        // Backpressure across two frames: first word held, second dropped
        set_delay(32'h1111_1111);
        axis_if.tready = 1'b0;
        w  = make_word(16'hC3C0, 1'b1);
        w2 = make_word(16'h3C30, 1'b1);
        exp_q.push_back(w);
        run_frame(w, 32'h1111_1111, 16, 1000);
        @(negedge aclk);
        check("bp_ovf_first", DW'(overflow_o), DW'(1'b0));
        run_frame(w2, 32'h1111_1111, 16, 1000);
        @(negedge aclk);
        check("bp_overflow", DW'(overflow_o), DW'(1'b1));
        check("bp_tvalid", DW'(axis_if.tvalid), DW'(1'b1));
        tick();
        axis_if.tready = 1'b1;
        drain("backpressure");
        @(negedge aclk);
        check("bp_tvalid_after", DW'(axis_if.tvalid), DW'(1'b0));
        check("bp_ovf_sticky", DW'(overflow_o), DW'(1'b1));
        pulse_clear();
        @(negedge aclk);
        check("clr_overflow", DW'(overflow_o), DW'(1'b0));

        // Short frame (10 bits) followed by a normal frame
        run_frame(make_word(16'h0F00, 1'b1), 32'h1111_1111, 10, 1000);
        @(negedge aclk);
        check("short_err_pending", DW'(frame_err_cnt_o), DW'(16'h0000));
        w = make_word(16'h5A50, 1'b1);
        exp_q.push_back(w);
        run_frame(w, 32'h1111_1111, 16, 1000);
        drain("short");
        @(negedge aclk);
        check("short_errcnt", DW'(frame_err_cnt_o), DW'(16'h0001));
        check("short_overflow", DW'(overflow_o), DW'(1'b0));
        pulse_clear();
        @(negedge aclk);
        check("clr_errcnt", DW'(frame_err_cnt_o), DW'(16'h0000));

        // Enable dropped after 8 bits, then a full frame
        run_frame(make_word(16'hFFF0, 1'b1), 32'h1111_1111, 16, 34);
        w = make_word(16'h6E60, 1'b1);
        exp_q.push_back(w);
        run_frame(w, 32'h1111_1111, 16, 1000);
        drain("abort");
        @(negedge aclk);
        check("abort_errcnt", DW'(frame_err_cnt_o), DW'(16'h0000));

        repeat (10) @(posedge aclk);
        @(negedge aclk);
        check("beat_count", DW'(beats), DW'(6));
        check("queue_empty", DW'(exp_q.size()), DW'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
